// File: rtl/up_down_bcd_counter_n.sv
// Cascadable N-decade BCD up/down counter with wrap or saturate behaviour at the
// boundaries, synchronous clear/load, and one-cycle status pulses.
module up_down_bcd_counter_n #(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned WRAP_MODE = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  sel,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  wrapped,
    output logic                  saturated,
    output logic                  load_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] count_q, count_d;
    logic [W-1:0] count_step;
    logic [W-1:0] load_fix;
    logic         wrapped_q, wrapped_d;
    logic         saturated_q, saturated_d;
    logic         load_err_q, load_err_d;

    logic         at_max, at_zero, load_bad, boundary;
    logic         carry;
    logic [3:0]   digit, ld_digit;

    // Per-digit decode: boundary detect, load clamping and the ripple carry/borrow chain.
    always_comb begin
        at_max     = 1'b1;
        at_zero    = 1'b1;
        load_bad   = 1'b0;
        load_fix   = '0;
        count_step = '0;
        carry      = 1'b1;
        digit      = 4'd0;
        ld_digit   = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit    = count_q[4*i +: 4];
            ld_digit = load_val[4*i +: 4];
            at_max   = at_max & (digit == 4'd9);
            at_zero  = at_zero & (digit == 4'd0);

            if (ld_digit > 4'd9) begin
                load_fix[4*i +: 4] = 4'd9;
                load_bad           = 1'b1;
            end else begin
                load_fix[4*i +: 4] = ld_digit;
            end

            if (!carry) begin
                count_step[4*i +: 4] = digit;
            end else if (!sel) begin
                count_step[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
                carry                = (digit == 4'd9);
            end else begin
                count_step[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
                carry                = (digit == 4'd0);
            end
        end
    end

    assign boundary = sel ? at_zero : at_max;
    assign tc       = en & boundary;

    always_comb begin
        count_d     = count_q;
        wrapped_d   = 1'b0;
        saturated_d = 1'b0;
        load_err_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d    = load_fix;
            load_err_d = load_bad;
        end else if (en) begin
            if (boundary && (WRAP_MODE == 0)) begin
                saturated_d = 1'b1;
            end else begin
                // At a boundary the ripple chain already lands on 0 / MAX.
                count_d   = count_step;
                wrapped_d = boundary;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            saturated_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            wrapped_q   <= wrapped_d;
            saturated_q <= saturated_d;
            load_err_q  <= load_err_d;
        end
    end

    assign count     = count_q;
    assign wrapped   = wrapped_q;
    assign saturated = saturated_q;
    assign load_err  = load_err_q;

endmodule
